// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding imem request, valid/ready output
// register to decode with a one-entry skid buffer, redirect flushes everything.
module if_stage #(
   parameter int unsigned         XLEN     = 64,
   parameter int unsigned         INST_LEN = 32,
   parameter logic [XLEN-1:0]     RESET_PC = 64'h0000_0000_8000_0000
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req_o,
   output logic [XLEN-1:0]     imem_addr_o,
   input  logic                imem_gnt_i,
   input  logic                imem_rvalid_i,
   input  logic [INST_LEN-1:0] imem_rdata_i,
   input  logic                redirect_i,
   input  logic [XLEN-1:0]     redirect_pc_i,
   input  logic                id_ready_i,
   output logic                id_valid_o,
   output logic [XLEN-1:0]     pc_o,
   output logic [INST_LEN-1:0] instr_o
);

   typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_FULL} state_e;

   state_e                state_q, state_d;
   logic [XLEN-1:0]       fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]       inflight_pc_q, inflight_pc_d;
   logic                  drop_q, drop_d;
   logic                  out_valid_q, out_valid_d;
   logic [XLEN-1:0]       out_pc_q, out_pc_d;
   logic [INST_LEN-1:0]   out_instr_q, out_instr_d;
   logic                  skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]       skid_pc_q, skid_pc_d;
   logic [INST_LEN-1:0]   skid_instr_q, skid_instr_d;

   logic                  out_free;
   logic [XLEN-1:0]       redirect_pc_aligned;

   assign out_free            = !out_valid_q || id_ready_i;
   assign redirect_pc_aligned = {redirect_pc_i[XLEN-1:2], 2'b00};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_BOOT;
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= '0;
         drop_q        <= 1'b0;
         out_valid_q   <= 1'b0;
         out_pc_q      <= '0;
         out_instr_q   <= '0;
         skid_valid_q  <= 1'b0;
         skid_pc_q     <= '0;
         skid_instr_q  <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         drop_q        <= drop_d;
         out_valid_q   <= out_valid_d;
         out_pc_q      <= out_pc_d;
         out_instr_q   <= out_instr_d;
         skid_valid_q  <= skid_valid_d;
         skid_pc_q     <= skid_pc_d;
         skid_instr_q  <= skid_instr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      drop_d        = drop_q;
      out_valid_d   = out_valid_q;
      out_pc_d      = out_pc_q;
      out_instr_d   = out_instr_q;
      skid_valid_d  = skid_valid_q;
      skid_pc_d     = skid_pc_q;
      skid_instr_d  = skid_instr_q;

      if (redirect_i) begin
         // Flush wins over everything, including a same-cycle consume.
         fetch_pc_d   = redirect_pc_aligned;
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
         drop_d       = 1'b0;
         case (state_q)
            S_REQ: begin
               if (imem_gnt_i) begin
                  drop_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid_i) state_d = S_REQ;
               else               drop_d  = 1'b1;
            end
            default: state_d = S_REQ;
         endcase
      end else begin
         if (out_valid_q && id_ready_i) out_valid_d = 1'b0;
         case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
               if (imem_gnt_i) begin
                  inflight_pc_d = fetch_pc_q;
                  fetch_pc_d    = fetch_pc_q + XLEN'(4);
                  state_d       = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid_i) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = S_REQ;
                  end else if (out_free) begin
                     out_valid_d = 1'b1;
                     out_pc_d    = inflight_pc_q;
                     out_instr_d = imem_rdata_i;
                     state_d     = S_REQ;
                  end else begin
                     skid_valid_d = 1'b1;
                     skid_pc_d    = inflight_pc_q;
                     skid_instr_d = imem_rdata_i;
                     state_d      = S_FULL;
                  end
               end
            end
            S_FULL: begin
               // Output is always valid here, so a consume frees it for the skid entry.
               if (id_ready_i && skid_valid_q) begin
                  out_valid_d  = 1'b1;
                  out_pc_d     = skid_pc_q;
                  out_instr_d  = skid_instr_q;
                  skid_valid_d = 1'b0;
                  state_d      = S_REQ;
               end
            end
            default: state_d = S_BOOT;
         endcase
      end
   end

   assign imem_req_o  = (state_q == S_REQ);
   assign imem_addr_o = fetch_pc_q;
   assign id_valid_o  = out_valid_q;
   assign pc_o        = out_pc_q;
   assign instr_o     = out_instr_q;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage that directly feeds the decode stage. It owns the fetch PC and issues one instruction-memory request at a time over a req/gnt + rvalid handshake. It presents {pc, instr} to decode through a valid/ready output register backed by a one-entry skid buffer. Redirects from branch, jump or trap resolution flush all in-flight and buffered work.

Parameters:
XLEN, 64, datapath and PC width
INST_LEN, 32, instruction width
RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset

Ports:
clk  in  1  single clock; all state changes on its rising edge
rst_n  in  1  reset, asynchronous, active-low
imem_req_o  out  1  fetch request; high exactly in state S_REQ
imem_addr_o  out  XLEN  fetch address (fetch_pc); stable while imem_req_o=1 and no redirect
imem_gnt_i  in  1  memory accepts the request this cycle
imem_rvalid_i  in  1  response valid; at most one per granted request
imem_rdata_i  in  INST_LEN  response instruction
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  XLEN  new fetch address; bits [1:0] are forced to 0
id_ready_i  in  1  decode accepts the output this cycle
id_valid_o  out  1  pc_o/instr_o hold a valid instruction
pc_o  out  XLEN  PC of the presented instruction
instr_o  out  INST_LEN  presented instruction

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0: state=S_BOOT, fetch_pc=RESET_PC, id_valid_o=0, skid_valid=0, drop=0, pc_o=0, instr_o=0, imem_req_o=0.
- Single outstanding request. Registers: fetch_pc, inflight_pc, drop flag, output reg {id_valid_o, pc_o, instr_o}, skid reg {skid_valid, skid_pc, skid_instr}.
- The output reg is "free" when id_valid_o=0 or id_ready_i=1 this cycle.
- FSM states:
  - S_BOOT -> S_REQ unconditionally. First request appears on the 2nd rising edge after rst_n deasserts.
  - S_REQ: imem_req_o=1, imem_addr_o=fetch_pc. On gnt: inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^XLEN, wraps), go to S_WAIT.
  - S_WAIT: no request. On rvalid with drop=1: discard, drop<=0, go to S_REQ.
  - S_WAIT, on rvalid with drop=0:
    - If the output reg is free: load {inflight_pc, rdata}, id_valid_o<=1, go to S_REQ.
    - Else: load the skid reg, skid_valid<=1, go to S_FULL.
  - S_FULL: no request. When id_ready_i=1: skid moves to the output reg (id_valid_o stays 1), skid_valid<=0, go to S_REQ.
- Output handshake:
  - pc_o and instr_o are held stable while id_valid_o=1 and id_ready_i=0.
  - A consume with no new data clears id_valid_o.
- Redirect has highest priority in every state. On a redirect edge:
  - fetch_pc<=redirect_pc_i with bits [1:0]=00.
  - id_valid_o<=0, skid_valid<=0.
  - id_ready_i in the same cycle is ignored.
  - S_REQ without gnt: stay in S_REQ; the new address appears next cycle.
  - S_REQ with gnt in the same cycle: drop<=1, go to S_WAIT. fetch_pc still takes redirect_pc and is not incremented.
  - S_WAIT without rvalid: drop<=1, stay in S_WAIT.
  - S_WAIT with rvalid in the same cycle: discard the response, drop<=0, go to S_REQ.
  - S_FULL, or S_BOOT: go to S_REQ.
- Throughput and latency:
  - Peak rate is one instruction per 2 cycles with 0-wait memory: S_REQ+gnt, then S_WAIT+rvalid.
  - rvalid to id_valid_o is 1 cycle.
- The decode stage never observes a stale instruction from before a redirect.
- imem_rvalid_i outside S_WAIT is ignored. Asserting it there is a protocol error and must be flagged by a bench assertion.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release. Required: imem_req_o=0 and id_valid_o=0 throughout reset; imem_req_o=1 with imem_addr_o=0x80000000 on the 2nd edge after release.
- Streaming: gnt=1 always, rvalid 1 cycle after gnt, id_ready=1, rdata=0x00000013,0x00100093,... Required: pc_o=0x80000000, 0x80000004, 0x80000008 with matching instr_o, id_valid_o high every other cycle.
- Backpressure: id_ready=0 after the first response. Required: the output holds 0x80000000; the 2nd response (0x80000004) goes into the skid; no request for 0x80000008 until id_ready=1; then 0x80000004 is presented on the next edge.
- Redirect in S_WAIT: redirect to 0x80001000 one cycle before rvalid. Required: the late response is dropped, id_valid_o=0, and the next request address is 0x80001000.
- Redirect coincident with gnt of 0x80000010, target 0x80002003. Required: the response for 0x80000010 is never presented, and the next request address is 0x80002000.
- Mid-operation reset: assert rst_n=0 asynchronously in S_FULL. Required: id_valid_o=0 immediately, without waiting for an edge; after release, fetch restarts at 0x80000000.
